regfile_onehot_wr: RTL and testbench

//  64-entry register file for the single-cycle processor. Writes are steered by the 64-bit one-hot

---
 rtl/regfile_pkg.sv | 7 +
 rtl/regfile_onehot_check.sv | 11 +
 rtl/regfile_onehot_wr.sv | 50 +++++
 tb/tb_regfile_onehot_wr.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes for the one-hot-write register file (entry count, read address width, default fault-counter width and its saturation value)
package regfile_pkg;
  localparam int NREGS = 64;
  localparam int RADDR_W = 6;
  localparam int ERRCNT_W_DEF = 8;
  localparam int ERRCNT_MAX = (1 << ERRCNT_W_DEF) - 1;
endpackage

// File: rtl/regfile_onehot_check.sv
// onehot_check: combinational popcount==1 test; in_vec[W] -> is_onehot
module onehot_check
  import regfile_pkg::*;
#(
  parameter int W = NREGS
) (
  input  logic [W-1:0] in_vec,
  output logic         is_onehot
);
  assign is_onehot = (in_vec != '0) && ((in_vec & (in_vec - W'(1))) == '0);
endmodule

// File: rtl/regfile_onehot_wr.sv
// regfile_onehot_wr: 64-entry regfile, one-hot write (clk, reset, we, wsel, wdata), two comb read ports (raddr_a/b -> rdata_a/b), fault pulse wr_err and saturating err_cnt
module regfile_onehot_wr
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b0,
  parameter int ERRCNT_W = ERRCNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [NREGS-1:0]    wsel,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [RADDR_W-1:0]  raddr_a,
  input  logic [RADDR_W-1:0]  raddr_b,
  output logic [DATA_W-1:0]   rdata_a,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                wr_err,
  output logic [ERRCNT_W-1:0] err_cnt
);
  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];
  logic wr_err_q, wr_err_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic is_onehot, wr_ok;
  onehot_check #(.W(NREGS)) u_check (.in_vec(wsel), .is_onehot(is_onehot));
  assign wr_ok = we && is_onehot;
  always_comb begin
    for (int i = 0; i < NREGS; i++)
      mem_d[i] = (wr_ok && wsel[i] && !(ZERO_REG && i == 0)) ? wdata : mem_q[i];
    wr_err_d = we && !is_onehot;
    err_cnt_d = (wr_err_d && err_cnt_q != '1) ? err_cnt_q + ERRCNT_W'(1) : err_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_err_q <= wr_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign rdata_a = (ZERO_REG && raddr_a == '0) ? '0 : (BYPASS && wr_ok && wsel[raddr_a]) ? wdata : mem_q[raddr_a];
  assign rdata_b = (ZERO_REG && raddr_b == '0) ? '0 : (BYPASS && wr_ok && wsel[raddr_b]) ? wdata : mem_q[raddr_b];
  assign wr_err = wr_err_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_regfile_onehot_wr.sv
// tb_regfile_onehot_wr: scoreboard bench driving two configurations (zero-reg/no-bypass and plain/bypass) from one stimulus stream
module tb_regfile_onehot_wr;
  logic clk = 1'b0;
  logic reset, we;
  logic [63:0] wsel;
  logic [31:0] wdata;
  logic [5:0] raddr_a, raddr_b;
  logic [31:0] ra_a, rb_a, ra_b, rb_b;
  logic err_a, err_b;
  logic [7:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  regfile_onehot_wr #(.DATA_W(32), .ZERO_REG(1'b1), .BYPASS(1'b0), .ERRCNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .we(we), .wsel(wsel), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra_a), .rdata_b(rb_a),
    .wr_err(err_a), .err_cnt(cnt_a));

  regfile_onehot_wr #(.DATA_W(32), .ZERO_REG(1'b0), .BYPASS(1'b1), .ERRCNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .we(we), .wsel(wsel), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra_b), .rdata_b(rb_b),
    .wr_err(err_b), .err_cnt(cnt_b));

  typedef struct {
    int cyc;
    logic [31:0] ra_a, rb_a, ra_b, rb_b;
    logic err;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  bit m_err;
  int m_cnt;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] model_rd(bit cfg_b, logic [5:0] a, bit ok, logic [63:0] s, logic [31:0] d);
    if (!cfg_b && a == 6'd0) return 32'd0;
    if (cfg_b && ok && s[a]) return d;
    return cfg_b ? mem_b[a] : mem_a[a];
  endfunction

  task automatic drive(input bit w, input logic [63:0] s, input logic [31:0] d, input logic [5:0] a, input logic [5:0] b);
    exp_t e;
    bit ok;
    @(posedge clk);
    #1;
    we = w; wsel = s; wdata = d; raddr_a = a; raddr_b = b;
    cyc++;
    ok = w && ($countones(s) == 1);
    e.cyc = cyc;
    e.ra_a = model_rd(1'b0, a, ok, s, d);
    e.rb_a = model_rd(1'b0, b, ok, s, d);
    e.ra_b = model_rd(1'b1, a, ok, s, d);
    e.rb_b = model_rd(1'b1, b, ok, s, d);
    e.err = m_err;
    e.cnt = 8'(m_cnt);
    sb.push_back(e);
    for (int k = 0; k < 64; k++)
      if (ok && s[k]) begin
        if (k != 0) mem_a[k] = d;
        mem_b[k] = d;
      end
    m_err = w && !ok;
    if (m_err && m_cnt < 255) m_cnt++;
  endtask

  task automatic check(input string n, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %h expected %h", n, c, act, exp);
    end
  endtask

  always @(negedge clk)
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("rdata_a(zr)", e.cyc, ra_a, e.ra_a);
      check("rdata_b(zr)", e.cyc, rb_a, e.rb_a);
      check("rdata_a(byp)", e.cyc, ra_b, e.ra_b);
      check("rdata_b(byp)", e.cyc, rb_b, e.rb_b);
      check("wr_err(zr)", e.cyc, {31'd0, err_a}, {31'd0, e.err});
      check("wr_err(byp)", e.cyc, {31'd0, err_b}, {31'd0, e.err});
      check("err_cnt(zr)", e.cyc, {24'd0, cnt_a}, {24'd0, e.cnt});
      check("err_cnt(byp)", e.cyc, {24'd0, cnt_b}, {24'd0, e.cnt});
    end

  function automatic logic [63:0] multi_hot();
    int i, j;
    i = $urandom_range(63, 0);
    j = (i + $urandom_range(63, 1)) % 64;
    return (64'd1 << i) | (64'd1 << j) | ({$urandom, $urandom} & {32'd0, $urandom});
  endfunction

  initial begin
    for (int k = 0; k < 64; k++) begin
      mem_a[k] = 32'd0;
      mem_b[k] = 32'd0;
    end
    m_err = 1'b0;
    m_cnt = 0;
    reset = 1'b1; we = 1'b1; wsel = 64'd1 << 5; wdata = 32'hDEAD; raddr_a = 6'd5; raddr_b = 6'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0; we = 1'b0;
    for (int k = 0; k < 32; k++)
      drive(1'b0, {$urandom, $urandom}, $urandom, 6'(k), 6'(k + 32));
    drive(1'b1, 64'd1 << 7, 32'h1234_5678, 6'd7, 6'd6);
    drive(1'b0, 64'd0, 32'd0, 6'd7, 6'd6);
    drive(1'b1, 64'd1 << 1, 32'h11, 6'd1, 6'd0);
    drive(1'b1, 64'h3, 32'hFFFF, 6'd0, 6'd1);
    drive(1'b1, 64'h0, 32'hEEEE, 6'd0, 6'd1);
    drive(1'b0, 64'h0, 32'd0, 6'd0, 6'd1);
    drive(1'b0, 64'h0, 32'd0, 6'd0, 6'd1);
    drive(1'b1, 64'd1, 32'hFFFF, 6'd0, 6'd0);
    drive(1'b0, 64'd1, 32'd0, 6'd0, 6'd0);
    drive(1'b1, 64'd1 << 9, 32'h55, 6'd3, 6'd4);
    drive(1'b1, 64'd1 << 9, 32'hAA, 6'd9, 6'd9);
    drive(1'b0, 64'd0, 32'd0, 6'd9, 6'd9);
    for (int n = 0; n < 400; n++) begin
      logic [63:0] s;
      logic [5:0] a, b;
      int mode;
      mode = $urandom_range(9, 0);
      s = (mode < 6) ? (64'd1 << $urandom_range(63, 0)) : (mode < 8) ? multi_hot() : (mode == 8) ? 64'd0 : {$urandom, $urandom};
      a = 6'($urandom_range(63, 0));
      b = 6'($urandom_range(63, 0));
      if ($urandom_range(3, 0) == 0 && mode < 6)
        for (int k = 0; k < 64; k++) if (s[k]) a = 6'(k);
      drive($urandom_range(3, 0) != 0, s, $urandom, a, b);
    end
    for (int n = 0; n < 300; n++)
      drive(1'b1, (n % 3 == 0) ? 64'd0 : multi_hot(), $urandom, 6'($urandom_range(63, 0)), 6'($urandom_range(63, 0)));
    drive(1'b1, 64'd1 << 20, 32'hCAFE_F00D, 6'd20, 6'd21);
    drive(1'b0, 64'd0, 32'd0, 6'd20, 6'd21);
    drive(1'b0, 64'd0, 32'd0, 6'd20, 6'd0);
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
